// File: rtl/bpb_table_if.sv
// Branch prediction buffer bus: fetch lookup, controller update and pipeline control.
// Width defaults come from the BPB_T macro (tag width) when it is defined.
`ifndef BPB_T
`define BPB_T 30
`endif

interface bpb_table_if #(
    parameter int TAG_WIDTH    = `BPB_T,
    parameter int TARGET_WIDTH = 32
);
    logic                    stall;
    logic                    flush;
    logic [TAG_WIDTH-1:0]    lk_tag;
    logic                    hit;
    logic                    pred_taken;
    logic [TARGET_WIDTH-1:0] pred_target;
    logic                    w_en;
    logic                    set_valid;
    logic [TAG_WIDTH-1:0]    set_tag;
    logic                    sw;
    logic [TARGET_WIDTH-1:0] set_target;
    logic                    conflict;

    modport master (
        output stall, flush, lk_tag, w_en, set_valid, set_tag, sw, set_target,
        input  hit, pred_taken, pred_target, conflict
    );

    modport slave (
        input  stall, flush, lk_tag, w_en, set_valid, set_tag, sw, set_target,
        output hit, pred_taken, pred_target, conflict
    );
endinterface

// File: rtl/bpb_table.sv
// Fully associative branch prediction buffer with 2-bit counters and a registered conflict flag.
// Macros: BPB_E (entries), BPB_T (tag width), BPB_LRU_EN (LRU victim instead of round-robin).
`ifndef BPB_E
`define BPB_E 8
`endif
`ifndef BPB_T
`define BPB_T 30
`endif

module bpb_table #(
    parameter int ENTRIES      = `BPB_E,
    parameter int TAG_WIDTH    = `BPB_T,
    parameter int TARGET_WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    bpb_table_if.slave bus
);
    localparam int IDXW = $clog2(ENTRIES);

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]    tag_q     [ENTRIES];
    logic [TAG_WIDTH-1:0]    tag_d     [ENTRIES];
    logic [TARGET_WIDTH-1:0] target_q  [ENTRIES];
    logic [TARGET_WIDTH-1:0] target_d  [ENTRIES];
    logic [1:0]              counter_q [ENTRIES];
    logic [1:0]              counter_d [ENTRIES];
    logic                    conflict_q, conflict_d;
`ifdef BPB_LRU_EN
    logic [IDXW-1:0]         age_q [ENTRIES];
    logic [IDXW-1:0]         age_d [ENTRIES];
`else
    logic [IDXW-1:0]         victim_q, victim_d;
`endif

    logic                    lkHit, lkTaken;
    logic [TARGET_WIDTH-1:0] lkTarget;
    logic                    updHit, freeFound;
    logic [IDXW-1:0]         updIdx, freeIdx, victimIdx, allocIdx;

    // Tags are unique among valid lines, so OR-reducing the matching fields selects one line.
    always_comb begin
        lkHit    = 1'b0;
        lkTaken  = 1'b0;
        lkTarget = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == bus.lk_tag) begin
                lkHit    = 1'b1;
                lkTaken  = lkTaken | counter_q[i][1];
                lkTarget = lkTarget | target_q[i];
            end
        end
    end

    assign bus.hit         = lkHit;
    assign bus.pred_taken  = lkTaken;
    assign bus.pred_target = lkTarget;
    assign bus.conflict    = conflict_q;

    always_comb begin
        updHit    = 1'b0;
        updIdx    = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == bus.set_tag) begin
                updHit = 1'b1;
                updIdx = IDXW'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDXW'(i);
            end
        end
    end

`ifdef BPB_LRU_EN
    // Ages form a permutation, so exactly one line carries the oldest age.
    always_comb begin
        victimIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_q[i] == IDXW'(ENTRIES - 1)) begin
                victimIdx = IDXW'(i);
            end
        end
    end
`else
    assign victimIdx = victim_q;
`endif

    assign allocIdx = freeFound ? freeIdx : victimIdx;

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        counter_d  = counter_q;
        conflict_d = 1'b0;
`ifdef BPB_LRU_EN
        age_d      = age_q;
`else
        victim_d   = victim_q;
`endif
        if (bus.flush) begin
            valid_d = '0;
`ifdef BPB_LRU_EN
            for (int i = 0; i < ENTRIES; i++) begin
                age_d[i] = IDXW'(i);
            end
`else
            victim_d = '0;
`endif
        end else if (bus.w_en) begin
            if (updHit && bus.set_valid) begin
                conflict_d = counter_q[updIdx][1] != bus.sw;
                if (bus.sw) begin
                    target_d[updIdx] = bus.set_target;
                    if (counter_q[updIdx] != 2'b11) begin
                        counter_d[updIdx] = counter_q[updIdx] + 2'd1;
                    end
                end else if (counter_q[updIdx] != 2'b00) begin
                    counter_d[updIdx] = counter_q[updIdx] - 2'd1;
                end
            end else if (updHit) begin
                valid_d[updIdx] = 1'b0;
            end else if (bus.set_valid) begin
                valid_d[allocIdx]   = 1'b1;
                tag_d[allocIdx]     = bus.set_tag;
                target_d[allocIdx]  = bus.set_target;
                counter_d[allocIdx] = bus.sw ? 2'b10 : 2'b01;
`ifndef BPB_LRU_EN
                if (!freeFound) begin
                    victim_d = victim_q + IDXW'(1);
                end
`endif
            end
`ifdef BPB_LRU_EN
            // The touched line becomes youngest; only lines younger than it age by one.
            if (bus.set_valid) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (IDXW'(j) == (updHit ? updIdx : allocIdx)) begin
                        age_d[j] = '0;
                    end else if (age_q[j] < age_q[updHit ? updIdx : allocIdx]) begin
                        age_d[j] = age_q[j] + IDXW'(1);
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            conflict_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                counter_q[i] <= 2'b01;
`ifdef BPB_LRU_EN
                age_q[i]     <= IDXW'(i);
`endif
            end
`ifndef BPB_LRU_EN
            victim_q <= '0;
`endif
        end else if (!bus.stall) begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            counter_q  <= counter_d;
            conflict_q <= conflict_d;
`ifdef BPB_LRU_EN
            age_q      <= age_d;
`else
            victim_q   <= victim_d;
`endif
        end
    end
endmodule

// File: tb/tb_bpb_table.sv
// Randomized bench for bpb_table against a recency-list reference model.
// Honours BPB_E, BPB_T and BPB_LRU_EN the same way the design does.
`ifndef BPB_E
`define BPB_E 8
`endif
`ifndef BPB_T
`define BPB_T 30
`endif

module tb_bpb_table;
    localparam int E  = `BPB_E;
    localparam int TW = `BPB_T;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bpb_table_if #(.TAG_WIDTH(TW), .TARGET_WIDTH(32)) bus ();

    bpb_table #(.ENTRIES(E), .TAG_WIDTH(TW), .TARGET_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: per-line fields plus a recency list (front = most recent).
    bit          mValid  [E];
    logic [TW-1:0] mTag  [E];
    int          mCnt    [E];
    logic [31:0] mTarget [E];
    int          mPtr;
    int          mOrder  [$];
    bit          mConflict;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic resetOrder();
        mOrder.delete();
        for (int i = 0; i < E; i++) mOrder.push_back(i);
    endtask

    task automatic modelReset();
        for (int i = 0; i < E; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = '0;
            mCnt[i]    = 1;
            mTarget[i] = '0;
        end
        mPtr      = 0;
        mConflict = 1'b0;
        resetOrder();
    endtask

    task automatic touch(input int k);
        for (int i = 0; i < mOrder.size(); i++) begin
            if (mOrder[i] == k) begin
                mOrder.delete(i);
                break;
            end
        end
        mOrder.push_front(k);
    endtask

    task automatic modelLookup(input logic [TW-1:0] lk, output bit h, output bit t, output logic [31:0] tgt);
        h = 1'b0; t = 1'b0; tgt = '0;
        for (int i = 0; i < E; i++) begin
            if (mValid[i] && mTag[i] == lk) begin
                h = 1'b1; t = (mCnt[i] >= 2); tgt = mTarget[i];
            end
        end
    endtask

    task automatic modelStep(input bit rst, st, fl, we, sv, input logic [TW-1:0] stag,
                             input bit sw, input logic [31:0] starget);
        int m, slot;
        if (rst) begin
            modelReset();
        end else if (st) begin
        end else if (fl) begin
            for (int i = 0; i < E; i++) mValid[i] = 1'b0;
            mPtr = 0;
            mConflict = 1'b0;
            resetOrder();
        end else begin
            mConflict = 1'b0;
            if (we) begin
                m = -1;
                for (int i = 0; i < E; i++) if (mValid[i] && mTag[i] == stag) m = i;
                if (m >= 0 && sv) begin
                    mConflict = ((mCnt[m] >= 2) != sw);
                    mCnt[m] = sw ? ((mCnt[m] + 1 > 3) ? 3 : mCnt[m] + 1)
                                 : ((mCnt[m] - 1 < 0) ? 0 : mCnt[m] - 1);
                    if (sw) mTarget[m] = starget;
                    touch(m);
                end else if (m >= 0) begin
                    mValid[m] = 1'b0;
                end else if (sv) begin
                    slot = -1;
                    for (int i = 0; i < E; i++) if (!mValid[i] && slot < 0) slot = i;
                    if (slot < 0) begin
`ifdef BPB_LRU_EN
                        slot = mOrder[E-1];
`else
                        slot = mPtr;
                        mPtr = (mPtr + 1) % E;
`endif
                    end
                    mValid[slot]  = 1'b1;
                    mTag[slot]    = stag;
                    mTarget[slot] = starget;
                    mCnt[slot]    = sw ? 2 : 1;
                    touch(slot);
                end
            end
        end
    endtask

    // One clock cycle: drive, check lookup against model, clock, check conflict.
    task automatic applyStimulus(input bit rst, st, fl, we, sv, input logic [TW-1:0] stag,
                                 input bit sw, input logic [31:0] starget, input logic [TW-1:0] lk);
        bit eHit, eTaken;
        logic [31:0] eTarget;
        @(negedge clk);
        reset          = rst;
        bus.stall      = st;
        bus.flush      = fl;
        bus.w_en       = we;
        bus.set_valid  = sv;
        bus.set_tag    = stag;
        bus.sw         = sw;
        bus.set_target = starget;
        bus.lk_tag     = lk;
        #1;
        modelLookup(lk, eHit, eTaken, eTarget);
        checkOutput("hit", bus.hit, eHit);
        checkOutput("pred_taken", bus.pred_taken, eTaken);
        checkOutput("pred_target", bus.pred_target, eTarget);
        @(posedge clk);
        modelStep(rst, st, fl, we, sv, stag, sw, starget);
        #1;
        checkOutput("conflict", bus.conflict, mConflict);
    endtask

    task automatic update(input logic [TW-1:0] t, input bit sw, input logic [31:0] tgt);
        applyStimulus(0, 0, 0, 1, 1, t, sw, tgt, t);
    endtask

    task automatic probe(input string name, input logic [TW-1:0] lk, input bit h, input bit tk,
                         input logic [31:0] tgt);
        applyStimulus(0, 0, 0, 0, 0, '0, 0, '0, lk);
        checkOutput({name, "_hit"}, bus.hit, h);
        checkOutput({name, "_taken"}, bus.pred_taken, tk);
        checkOutput({name, "_target"}, bus.pred_target, tgt);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.w_en = 0; bus.set_valid = 0;
        bus.set_tag = '0; bus.sw = 0; bus.set_target = '0; bus.lk_tag = '0;
        @(posedge clk);
        modelReset();
        #1;
        checkOutput("reset_conflict", bus.conflict, 1'b0);

        probe("reset", TW'(32'h10), 0, 0, 32'h0);
        checkOutput("reset_idle_conflict", bus.conflict, 1'b0);

        update(TW'(32'h10), 1, 32'h400);
        checkOutput("alloc_conflict", bus.conflict, 1'b0);
        probe("alloc", TW'(32'h10), 1, 1, 32'h400);

        update(TW'(32'h10), 0, 32'h999);
        checkOutput("train1_conflict", bus.conflict, 1'b1);
        update(TW'(32'h10), 0, 32'h999);
        checkOutput("train2_conflict", bus.conflict, 1'b0);
        probe("train", TW'(32'h10), 1, 0, 32'h400);

        applyStimulus(0, 1, 0, 1, 1, TW'(32'h20), 1, 32'h500, TW'(32'h20));
        probe("stall", TW'(32'h20), 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 1, 1, TW'(32'h30), 1, 32'h600, TW'(32'h30));
        probe("flush_new", TW'(32'h30), 0, 0, 32'h0);
        probe("flush_old", TW'(32'h10), 0, 0, 32'h0);

        applyStimulus(1, 0, 0, 0, 0, '0, 0, '0, '0);
        for (int i = 0; i < E; i++) update(TW'(32'h100 + i), 1, 32'h1000 + i);
        update(TW'(32'h100), 1, 32'h1000);
        update(TW'(32'h200), 1, 32'h2000);
`ifdef BPB_LRU_EN
        probe("lru_keep0", TW'(32'h100), 1, 1, 32'h1000);
        probe("lru_evict1", TW'(32'h101), 0, 0, 32'h0);
        update(TW'(32'h201), 1, 32'h2001);
        probe("lru_evict2", TW'(32'h102), 0, 0, 32'h0);
`else
        probe("rr_evict0", TW'(32'h100), 0, 0, 32'h0);
        probe("rr_new", TW'(32'h200), 1, 1, 32'h2000);
        update(TW'(32'h201), 1, 32'h2001);
        probe("rr_evict1", TW'(32'h101), 0, 0, 32'h0);
        probe("rr_keep2", TW'(32'h102), 1, 1, 32'h1002);
`endif

        update(TW'(32'h103), 0, 32'h0);
        checkOutput("pre_reset_conflict", bus.conflict, 1'b1);
        applyStimulus(1, 0, 0, 1, 1, TW'(32'h40), 1, 32'h44, TW'(32'h40));
        checkOutput("mid_reset_conflict", bus.conflict, 1'b0);
        probe("mid_reset_new", TW'(32'h40), 0, 0, 32'h0);
        probe("mid_reset_old", TW'(32'h103), 0, 0, 32'h0);

        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 80,
                          TW'($urandom_range(0, E + 3)),
                          $urandom_range(0, 1) == 1,
                          $urandom,
                          TW'($urandom_range(0, E + 3)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
